// File: rtl/inst_fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and the 256x8 instruction RAM.
interface inst_fetch_stage_if;
  logic        MemEnable;
  logic [31:0] MemAddress;
  logic [31:0] MemDataOut;

  // Fetch stage side: drives enable/address, receives the read word.
  modport master (
    output MemEnable,
    output MemAddress,
    input  MemDataOut
  );

  // RAM side: receives enable/address, returns the 4 bytes at MemAddress.
  modport slave (
    input  MemEnable,
    input  MemAddress,
    output MemDataOut
  );
endinterface

// File: rtl/inst_fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the instruction RAM, and fills
// the IF/ID pipeline register. Handles hazard stalls and taken-branch
// redirects, which flush IF/ID to a bubble.
module inst_fetch_stage #(
  parameter int unsigned MEM_BYTES = 256,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'hE1A0_0000
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       Stall,
  input  logic                       BranchTaken,
  input  logic [31:0]                BranchTarget,
  inst_fetch_stage_if.master         mem,
  output logic [31:0]                IfId_Instr,
  output logic [31:0]                IfId_PC4,
  output logic                       IfId_Valid,
  output logic [31:0]                FetchPC,
  output logic [15:0]                InstrCount
);

  localparam logic [31:0] ADDR_MASK = 32'(MEM_BYTES - 1);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_capture;
  logic        w_flush;

  logic        r_mem_en;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc4;
  logic        r_valid;
  logic [15:0] r_cnt;

  // Next sequential word address, wrapping at the end of instruction memory.
  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return (pc + 32'd4) & ADDR_MASK;
  endfunction

  // Branch target forced into range and onto a word boundary.
  function automatic logic [31:0] redirect_pc(input logic [31:0] tgt);
    return tgt & ADDR_MASK & ~32'd3;
  endfunction

  // Capture counter that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // State register; BOOT on reset gives the RAM its precharge cycle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= S_BOOT;
    else          r_state <= w_state_nxt;
  end

  // Next-state and action decode; branch beats stall, and leaving HOLD
  // captures on the same edge, so RUN and HOLD share one decision tree.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_flush     = 1'b0;
    case (r_state)
      S_BOOT: w_state_nxt = S_RUN;
      S_RUN, S_HOLD: begin
        if (BranchTaken) begin
          w_flush     = 1'b1;
          w_state_nxt = S_RUN;
        end else if (Stall) begin
          w_state_nxt = S_HOLD;
        end else begin
          w_capture   = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      default: w_state_nxt = S_BOOT;
    endcase
  end

  // Registered RAM enable so the memory pins have no path from inputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_mem_en <= 1'b0;
    else          r_mem_en <= (w_state_nxt != S_BOOT);
  end

  // PC, IF/ID register and capture counter.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_pc    <= RESET_PC;
      r_instr <= NOP_INSTR;
      r_pc4   <= 32'd0;
      r_valid <= 1'b0;
      r_cnt   <= 16'd0;
    end else if (w_flush) begin
      r_pc    <= redirect_pc(BranchTarget);
      r_instr <= NOP_INSTR;
      r_pc4   <= 32'd0;
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_pc    <= seq_pc(r_pc);
      r_instr <= mem.MemDataOut;
      r_pc4   <= seq_pc(r_pc);
      r_valid <= 1'b1;
      r_cnt   <= sat_inc(r_cnt);
    end
  end

  assign mem.MemEnable  = r_mem_en;
  assign mem.MemAddress = r_pc;
  assign FetchPC        = r_pc;
  assign IfId_Instr     = r_instr;
  assign IfId_PC4       = r_pc4;
  assign IfId_Valid     = r_valid;
  assign InstrCount     = r_cnt;

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Bench for inst_fetch_stage: directed vector table, async-reset sequence,
// then randomized stall/branch traffic against a behavioural fetch model.
module tb_inst_fetch_stage;

  localparam logic [31:0] NOP = 32'hE1A0_0000;

  logic        Clk;
  logic        Reset_n;
  logic        Stall;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic [31:0] IfId_Instr;
  logic [31:0] IfId_PC4;
  logic        IfId_Valid;
  logic [31:0] FetchPC;
  logic [15:0] InstrCount;

  logic [31:0] mem_w [0:63];

  int n_vec = 0;
  int n_err = 0;

  inst_fetch_stage_if bus();

  assign bus.MemDataOut = mem_w[bus.MemAddress[7:2]];

  inst_fetch_stage #(
    .MEM_BYTES (256),
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .Stall        (Stall),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .mem          (bus),
    .IfId_Instr   (IfId_Instr),
    .IfId_PC4     (IfId_PC4),
    .IfId_Valid   (IfId_Valid),
    .FetchPC      (FetchPC),
    .InstrCount   (InstrCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        en;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [15:0] cnt;
  } vec_t;

  vec_t vt [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic en, input logic [31:0] pc,
                         input logic [31:0] instr, input logic [31:0] pc4,
                         input logic valid, input logic [15:0] cnt);
    chk({nm, ".MemEnable"},  {31'd0, bus.MemEnable}, {31'd0, en});
    chk({nm, ".MemAddress"}, bus.MemAddress, pc);
    chk({nm, ".FetchPC"},    FetchPC, pc);
    chk({nm, ".Instr"},      IfId_Instr, instr);
    chk({nm, ".PC4"},        IfId_PC4, pc4);
    chk({nm, ".Valid"},      {31'd0, IfId_Valid}, {31'd0, valid});
    chk({nm, ".Count"},      {16'd0, InstrCount}, {16'd0, cnt});
  endtask

  task automatic step(input logic s, input logic b, input logic [31:0] t);
    Stall        = s;
    BranchTaken  = b;
    BranchTarget = t;
    @(posedge Clk);
    #1;
  endtask

  // Behavioural model state
  logic        m_boot;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_valid;
  int          m_cnt;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) mem_w[i] = 32'hA500_0000 | 32'(i * 4);
    mem_w[0]  = 32'hE3A0_1005;
    mem_w[1]  = 32'hE3A0_2003;
    mem_w[2]  = 32'hE081_3002;
    mem_w[4]  = 32'hE3A0_300F;
    mem_w[16] = 32'hE281_1001;
    mem_w[63] = 32'hEAFF_FFFE;

    //           stall br   tgt            en   pc          instr         pc4         v    cnt
    vt[0]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h00, NOP,          32'h00, 1'b0, 16'd0};
    vt[1]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h04, 32'hE3A01005, 32'h04, 1'b1, 16'd1};
    vt[2]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h08, 32'hE3A02003, 32'h08, 1'b1, 16'd2};
    vt[3]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h08, 32'hE3A02003, 32'h08, 1'b1, 16'd2};
    vt[4]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h08, 32'hE3A02003, 32'h08, 1'b1, 16'd2};
    vt[5]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h08, 32'hE3A02003, 32'h08, 1'b1, 16'd2};
    vt[6]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0C, 32'hE0813002, 32'h0C, 1'b1, 16'd3};
    vt[7]  = '{1'b0, 1'b1, 32'h42,       1'b1, 32'h40, NOP,          32'h00, 1'b0, 16'd3};
    vt[8]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h44, 32'hE2811001, 32'h44, 1'b1, 16'd4};
    vt[9]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h44, 32'hE2811001, 32'h44, 1'b1, 16'd4};
    vt[10] = '{1'b1, 1'b1, 32'h10,       1'b1, 32'h10, NOP,          32'h00, 1'b0, 16'd4};
    vt[11] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h14, 32'hE3A0300F, 32'h14, 1'b1, 16'd5};
    vt[12] = '{1'b0, 1'b1, 32'hFC,       1'b1, 32'hFC, NOP,          32'h00, 1'b0, 16'd5};
    vt[13] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h00, 32'hEAFFFFFE, 32'h00, 1'b1, 16'd6};
    vt[14] = '{1'b0, 1'b1, 32'hFFFFFF07, 1'b1, 32'h04, NOP,          32'h00, 1'b0, 16'd6};
    vt[15] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h08, 32'hE3A02003, 32'h08, 1'b1, 16'd7};

    Reset_n      = 1'b0;
    Stall        = 1'b0;
    BranchTaken  = 1'b0;
    BranchTarget = 32'd0;

    // Reset values while held in reset across edges
    repeat (2) @(posedge Clk);
    #2;
    chk_all("reset", 1'b0, 32'h0, NOP, 32'h0, 1'b0, 16'd0);

    // Release between edges; still BOOT until the next edge
    @(negedge Clk);
    Reset_n = 1'b1;
    #1;
    chk_all("boot", 1'b0, 32'h0, NOP, 32'h0, 1'b0, 16'd0);

    // Directed table: boot, stall, branch, branch-during-stall, wrap, masking
    for (int i = 0; i < 16; i++) begin
      step(vt[i].stall, vt[i].br, vt[i].tgt);
      chk_all($sformatf("vec%0d", i), vt[i].en, vt[i].pc, vt[i].instr,
              vt[i].pc4, vt[i].valid, vt[i].cnt);
    end

    // Async reset pulse between edges, released before the next edge
    step(1'b1, 1'b0, 32'h0);
    #2;
    Reset_n = 1'b0;
    #1;
    chk_all("async_rst", 1'b0, 32'h0, NOP, 32'h0, 1'b0, 16'd0);
    #1;
    Reset_n = 1'b1;
    step(1'b0, 1'b0, 32'h0);
    chk_all("reboot1", 1'b1, 32'h0, NOP, 32'h0, 1'b0, 16'd0);
    step(1'b0, 1'b0, 32'h0);
    chk_all("reboot2", 1'b1, 32'h4, 32'hE3A01005, 32'h4, 1'b1, 16'd1);

    // Randomized traffic checked against a behavioural model
    m_boot  = 1'b0;
    m_pc    = 32'h4;
    m_instr = 32'hE3A0_1005;
    m_pc4   = 32'h4;
    m_valid = 1'b1;
    m_cnt   = 1;
    for (int i = 0; i < 400; i++) begin
      logic        s;
      logic        b;
      logic [31:0] t;
      s = ($urandom_range(0, 9) < 3);
      b = ($urandom_range(0, 19) < 3);
      t = $urandom();
      step(s, b, t);
      if (m_boot) begin
        m_boot = 1'b0;
      end else if (b) begin
        m_pc    = (t % 256) / 4 * 4;
        m_instr = NOP;
        m_pc4   = 32'd0;
        m_valid = 1'b0;
      end else if (!s) begin
        m_instr = mem_w[m_pc / 4];
        m_pc    = (m_pc + 4) % 256;
        m_pc4   = m_pc;
        m_valid = 1'b1;
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
      end
      chk_all($sformatf("rand%0d", i), !m_boot, m_pc, m_instr, m_pc4, m_valid, 16'(m_cnt));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
